freq_meas_ctrl: RTL

Measurement sequencer and auto-ranging controller for the frequency meter datapath. It drives the BCD counter's clear/enable controls and the display latch-load strobe from `sysclk`, replacing the free-running half-second control clock. In auto mode it selects the ÷1 or ÷10 input range from the counter's overflow flag and most-significant digit, retrying a measurement once when the range changes. It sits between the front-panel switches and the counter/latch/decoder chain.

---
 rtl/freq_meas_ctrl_if.sv | 28 ++
 rtl/freq_meas_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/freq_meas_ctrl_if.sv
// Control/status bundle between the front panel, the BCD counter chain and the
// measurement sequencer; master is the sequencer, slave is the panel/counter side.
interface freq_meas_ctrl_if;
   localparam int unsigned MSD_W = 4;

   logic             start;
   logic             auto;
   logic             range_in;
   logic             ovf;
   logic [MSD_W-1:0] msd;
   logic             count_clear;
   logic             count_ena;
   logic             load;
   logic             range;
   logic             valid;
   logic             ovf_o;
   logic             busy;

   modport master (
      input  start, auto, range_in, ovf, msd,
      output count_clear, count_ena, load, range, valid, ovf_o, busy
   );

   modport slave (
      output start, auto, range_in, ovf, msd,
      input  count_clear, count_ena, load, range, valid, ovf_o, busy
   );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Frequency meter measurement sequencer: clear/gate/settle/load timing on sysclk
// plus one-shot auto-ranging between the /1 and /10 inputs.
module freq_meas_ctrl #(
   parameter int unsigned GATE_CYCLES   = 50_000_000,
   parameter int unsigned CLR_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic             sysclk,
   input  logic             rst,
   freq_meas_ctrl_if.master bus
);
   localparam int unsigned MAX_CG     = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
   localparam int unsigned MAX_CYCLES = (MAX_CG > SETTLE_CYCLES) ? MAX_CG : SETTLE_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_GATE   = 3'd2,
      S_SETTLE = 3'd3,
      S_LOAD   = 3'd4,
      S_DECIDE = 3'd5
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             retry, retry_nx;
   logic             retry_pend, retry_pend_nx;
   logic             range_pend, range_pend_nx;
   logic             up_c, dn_c;

   logic count_clear_q, count_ena_q, load_q, range_q, valid_q, ovf_o_q, busy_q;
   logic count_clear_d, count_ena_d, load_d, range_d, valid_d, ovf_o_d, busy_d;

   assign bus.count_clear = count_clear_q;
   assign bus.count_ena   = count_ena_q;
   assign bus.load        = load_q;
   assign bus.range       = range_q;
   assign bus.valid       = valid_q;
   assign bus.ovf_o       = ovf_o_q;
   assign bus.busy        = busy_q;

   // Range decision evaluated while the latch loads; only one retry per result.
   assign up_c = bus.auto && !retry && !range_q && bus.ovf;
   assign dn_c = bus.auto && !retry && range_q && !bus.ovf && (bus.msd == '0);

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         retry      <= 1'b0;
         retry_pend <= 1'b0;
         range_pend <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         retry      <= retry_nx;
         retry_pend <= retry_pend_nx;
         range_pend <= range_pend_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (bus.start) state_nx = S_CLEAR;
         S_CLEAR:  if (cnt == '0) state_nx = S_GATE;
         S_GATE:   if (cnt == '0) state_nx = S_SETTLE;
         S_SETTLE: if (cnt == '0) state_nx = S_LOAD;
         S_LOAD:   state_nx = S_DECIDE;
         S_DECIDE: state_nx = (retry_pend || bus.start) ? S_CLEAR : S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Phase counter reloads with (length-1) on every state entry and counts down to zero.
   always_comb begin
      cnt_nx = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
      if (state_nx != state) begin
         unique case (state_nx)
            S_CLEAR:  cnt_nx = CNT_W'(CLR_CYCLES - 1);
            S_GATE:   cnt_nx = CNT_W'(GATE_CYCLES - 1);
            S_SETTLE: cnt_nx = CNT_W'(SETTLE_CYCLES - 1);
            default:  cnt_nx = '0;
         endcase
      end
   end

   always_comb begin
      retry_nx      = retry;
      retry_pend_nx = retry_pend;
      range_pend_nx = range_pend;
      count_clear_d = (state_nx == S_IDLE) || (state_nx == S_CLEAR);
      count_ena_d   = (state_nx == S_GATE);
      load_d        = (state_nx == S_LOAD);
      busy_d        = (state_nx != S_IDLE);
      valid_d       = 1'b0;
      ovf_o_d       = ovf_o_q;
      range_d       = range_q;

      if (state == S_LOAD) begin
         retry_pend_nx = up_c || dn_c;
         range_pend_nx = up_c;
         retry_nx      = up_c || dn_c;
         valid_d       = !(up_c || dn_c);
         if (!(up_c || dn_c)) ovf_o_d = bus.ovf;
      end

      // Range only moves on entry to CLEAR so it is stable across clear and gate.
      if (state == S_IDLE && bus.start && !bus.auto) begin
         range_d = bus.range_in;
      end else if (state == S_DECIDE && retry_pend) begin
         range_d       = range_pend;
         retry_pend_nx = 1'b0;
      end
   end

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         count_clear_q <= 1'b1;
         count_ena_q   <= 1'b0;
         load_q        <= 1'b0;
         range_q       <= 1'b0;
         valid_q       <= 1'b0;
         ovf_o_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         count_clear_q <= count_clear_d;
         count_ena_q   <= count_ena_d;
         load_q        <= load_d;
         range_q       <= range_d;
         valid_q       <= valid_d;
         ovf_o_q       <= ovf_o_d;
         busy_q        <= busy_d;
      end
   end
endmodule
